// File: rtl/cdm_seq_mul.sv
// Sequential carry-disregard approximate multiplier: B is consumed SLICE bits per clock,
// and each slice's partial product is folded into the accumulator with an optionally carry-free adder.
module cdm_seq_mul #(
    parameter int WIDTH       = 8,
    parameter int SLICE       = 4,
    parameter int APPROX_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] R,
    output logic               busy
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = WIDTH + SLICE;
    localparam int RW = 2 * WIDTH;

    // Positions below APPROX_BITS combine by XOR in approximate mode
    localparam logic [RW:0]   ONE_EXT     = (RW+1)'(1);
    localparam logic [RW:0]   MASK_EXT    = (ONE_EXT << APPROX_BITS) - ONE_EXT;
    localparam logic [RW-1:0] APPROX_MASK = MASK_EXT[RW-1:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            mode_q, mode_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [31:0]      shamt_s;
    logic [SLICE-1:0] slice_s;
    logic [PW-1:0]    pp_s;
    logic [RW-1:0]    shifted_s;
    logic [RW-1:0]    sum_s;
    logic             last_slice_s;

    // The upper field is added with its carry-in forced to zero by masking out the low field
    function automatic logic [RW-1:0] cdadd(input logic [RW-1:0] x,
                                            input logic [RW-1:0] y,
                                            input logic          m);
        logic [RW-1:0] res;
        if (m) begin
            res = ((x & ~APPROX_MASK) + (y & ~APPROX_MASK)) | ((x ^ y) & APPROX_MASK);
        end else begin
            res = x + y;
        end
        return res;
    endfunction

    // State, operand, accumulator and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            mode_q      <= 1'b0;
            acc_q       <= {RW{1'b0}};
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (last_slice_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they leave a flop
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            S_IDLE:  in_ready_d  = 1'b1;
            S_BUSY:  busy_d      = 1'b1;
            S_DONE:  out_valid_d = 1'b1;
            default: in_ready_d  = 1'b1;
        endcase
    end

    // One slice of partial product per cycle, shifted into place and accumulated
    always_comb begin
        shamt_s      = 32'(cnt_q) * 32'(SLICE);
        slice_s      = SLICE'(b_q >> shamt_s);
        pp_s         = PW'(a_q) * PW'(slice_s);
        shifted_s    = RW'(pp_s) << shamt_s;
        sum_s        = cdadd(acc_q, shifted_s, mode_q);
        last_slice_s = (cnt_q == CW'(N - 1));

        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d    = A;
                    b_d    = B;
                    mode_d = mode;
                    acc_d  = {RW{1'b0}};
                    cnt_d  = {CW{1'b0}};
                end else begin
                    acc_d  = acc_q;
                end
            end
            S_BUSY: begin
                acc_d = sum_s;
                cnt_d = cnt_q + CW'(1);
            end
            S_DONE:  acc_d = acc_q;
            default: acc_d = acc_q;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign R         = acc_q;

endmodule
